pbl_request_capture: RTL
========================

// Module: pbl_request_capture
// PURPOSE
//  Upstream stage of the access-control decoder. Synchronises and debounces the raw
//  profile switches (CH7..CH5), the function switch (CH4) and the buttons (B3, B2).
//  Each stable change becomes one committed request (PROFILE, FUNC), offered with a
//  valid/ready handshake to the profile/function decoder that drives the LEDs and
//  the M1 matrix.
// PARAMETERS
//  DEB_CYCLES   16     consecutive stable cycles required before commit (>=2)
//  MAX_FAIL     3      consecutive non-privileged commits before lockout (LOCKOUT_EN only)
//  LOCK_CYCLES  64     lockout duration in clock cycles (LOCKOUT_EN only)
// PORTS
//  CLK        in   1  system clock; all logic on the rising edge
//  RST_N      in   1  synchronous, active-low reset
//  CH7..CH4   in   1  raw asynchronous switches
//  B3, B2     in   1  raw asynchronous buttons, active-high level
//  REQ_READY  in   1  downstream decoder accepts the request
//  REQ_VALID  out  1  committed request pending
//  PROFILE    out  3  committed {CH7,CH6,CH5}
//  FUNC       out  3  committed {B3,B2,CH4}; 0 means no function selected
//  REQ_COUNT  out  8  number of accepted requests; wraps 255->0
//  LOCKED     out  1  lockout active; tied 0 when LOCKOUT_EN is undefined
// BEHAVIOUR
//  - Reset (RST_N=0 at an edge, from any state): state=IDLE; sync flops, candidate K,
//    committed C, count and fail counter all 0; every output 0.
//  - Two-flop synchroniser on all six inputs. S = synchronised 6-bit vector
//    {CH7,CH6,CH5,B3,B2,CH4}.
//  - IDLE: if S!=C, set K<=S and cnt<=0, then go to SETTLE. Otherwise stay.
//  - SETTLE: if S!=K, set K<=S and cnt<=0 (restart the count). Else if
//    cnt==DEB_CYCLES-1, set C<=K and go to COMMIT. Else cnt<=cnt+1.
//  - SETTLE with S returning to C: the count still runs. It commits the same value
//    again, so the glitch produces a request.
//  - COMMIT: REQ_VALID=1. PROFILE/FUNC=C, held stable while REQ_VALID=1. Input changes
//    are ignored here; they are detected on return to IDLE.
//  - COMMIT to IDLE: on the edge with REQ_READY=1, set REQ_VALID<=0, REQ_COUNT+=1
//    (mod 256) and go to IDLE.
//  - REQ_READY has no effect outside COMMIT.
//  - PROFILE/FUNC always show C and keep it after the handshake completes.
//  - Latency: a raw change first sampled at edge n gives REQ_VALID=1 after edge
//    n+DEB_CYCLES+2, provided there is no bounce.
//  - A combined ready-and-change happens when REQ_READY=1 in COMMIT while S already
//    differs from C. The FSM goes to IDLE, and the next edge starts SETTLE.
//  - cnt width is $clog2(DEB_CYCLES). Overflow cannot occur because the compare
//    precedes the increment.
// CONFIGURATION
//  LOCKOUT_EN defined:
//  - A privileged profile is 3'b101 (admin) or 3'b011 (tester).
//  - On handshake completion, a privileged PROFILE clears fail_cnt. Any other profile
//    sets fail_cnt+=1.
//  - If the new fail_cnt==MAX_FAIL, go to LOCKED instead of IDLE.
//  - LOCKED: LOCKED=1, REQ_VALID=0, inputs ignored, K/C unchanged. After LOCK_CYCLES
//    cycles: fail_cnt<=0, LOCKED<=0, go to IDLE.
//  - Reset inside LOCKED exits immediately.
//  LOCKOUT_EN undefined: no LOCKED state and no fail counter; LOCKED=0 constantly.
// TESTING  (DEB_CYCLES=4, MAX_FAIL=3, LOCK_CYCLES=8)
//  1 Reset: RST_N=0 for 2 cycles -> all outputs 0, then IDLE with no request while
//    inputs=0.
//  2 Clean change: CH7,CH5=1 sampled at edge n -> REQ_VALID=1 after edge n+6 with
//    PROFILE=3'b101, FUNC=0. REQ_READY=1 -> REQ_VALID=0 next edge, REQ_COUNT=1.
//  3 Bounce: toggle B3 every 2 cycles for 10 cycles, then hold B3=1 -> exactly one
//    request, FUNC=3'b100, 6 edges after the last toggle.
//  4 Backpressure: REQ_READY=0 for 20 cycles while CH4 changes -> PROFILE/FUNC stay
//    stable. After REQ_READY=1, a second request follows with FUNC bit0=1.
//  5 Reset mid-SETTLE: RST_N=0 at cnt=2 -> REQ_VALID never asserts, and C=0.
//  6 LOCKOUT_EN: 3 accepted requests with PROFILE=3'b001 -> LOCKED=1 for 8 cycles,
//    no REQ_VALID. Then a PROFILE=3'b011 request is accepted and fail_cnt returns to 0.

Source files
------------

// File: rtl/pbl_request_capture.sv
// pbl_request_capture
//   Upstream stage of the access-control decoder. Synchronises and debounces the
//   raw profile switches (CH7..CH5), the function switch (CH4) and the buttons
//   (B3, B2). Each stable change is committed as one request (PROFILE, FUNC)
//   and offered to the downstream decoder with a valid/ready handshake.
//
//   Optional feature: define LOCKOUT_EN to enable the lockout after MAX_FAIL
//   consecutive non-privileged requests (privileged profiles: 3'b101, 3'b011).
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   synchronous active-low reset
//   CH7..CH4   in   raw asynchronous switches
//   B3, B2     in   raw asynchronous buttons (active-high level)
//   REQ_READY  in   downstream accepts the pending request
//   REQ_VALID  out  committed request pending
//   PROFILE    out  committed {CH7,CH6,CH5}
//   FUNC       out  committed {B3,B2,CH4}
//   REQ_COUNT  out  accepted request count, wraps at 256
//   LOCKED     out  lockout active (0 without LOCKOUT_EN)
module pbl_request_capture #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CH7,
  input  logic       CH6,
  input  logic       CH5,
  input  logic       CH4,
  input  logic       B3,
  input  logic       B2,
  input  logic       REQ_READY,
  output logic       REQ_VALID,
  output logic [2:0] PROFILE,
  output logic [2:0] FUNC,
  output logic [7:0] REQ_COUNT,
  output logic       LOCKED
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  if (DEB_CYCLES < 2 || MAX_FAIL < 1 || LOCK_CYCLES < 2) begin : g_bad_cfg
    $error("pbl_request_capture: unsupported parameter values");
  end

`ifdef LOCKOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COMMIT, ST_LOCK} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COMMIT} state_t;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_sync1;
  logic [5:0]         r_sync2;
  logic [5:0]         r_k;
  logic [5:0]         r_c;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_count;
  logic [5:0]         w_raw;
  logic               w_cnt_done;

  assign w_raw      = {CH7, CH6, CH5, B3, B2, CH4};
  assign w_cnt_done = (r_cnt == CNT_W'(DEB_CYCLES - 1));

`ifdef LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES);

  logic [FAIL_W-1:0]  r_fail;
  logic [FAIL_W-1:0]  w_fail_next;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic               w_priv;
  logic               w_lock_done;

  assign w_priv      = (r_c[5:3] == 3'b101) || (r_c[5:3] == 3'b011);
  assign w_fail_next = w_priv ? '0 : r_fail + FAIL_W'(1);
  assign w_lock_done = (r_lock_cnt == LOCK_W'(LOCK_CYCLES - 1));
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (r_sync2 != r_c) w_next = ST_SETTLE;
      ST_SETTLE: if (r_sync2 == r_k && w_cnt_done) w_next = ST_COMMIT;
      ST_COMMIT: begin
        if (REQ_READY) begin
`ifdef LOCKOUT_EN
          w_next = (w_fail_next == FAIL_W'(MAX_FAIL)) ? ST_LOCK : ST_IDLE;
`else
          w_next = ST_IDLE;
`endif
        end
      end
`ifdef LOCKOUT_EN
      ST_LOCK:   if (w_lock_done) w_next = ST_IDLE;
`endif
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    REQ_VALID = (r_state == ST_COMMIT);
`ifdef LOCKOUT_EN
    LOCKED    = (r_state == ST_LOCK);
`else
    LOCKED    = 1'b0;
`endif
  end

  assign PROFILE   = r_c[5:3];
  assign FUNC      = r_c[2:0];
  assign REQ_COUNT = r_count;

  // Synchroniser, debounce datapath and counters
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_k        <= '0;
      r_c        <= '0;
      r_cnt      <= '0;
      r_count    <= '0;
`ifdef LOCKOUT_EN
      r_fail     <= '0;
      r_lock_cnt <= '0;
`endif
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      case (r_state)
        ST_IDLE: begin
          if (r_sync2 != r_c) begin
            r_k   <= r_sync2;
            r_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          // A return to C does not abort: the same value is re-committed.
          if (r_sync2 != r_k) begin
            r_k   <= r_sync2;
            r_cnt <= '0;
          end else if (w_cnt_done) begin
            r_c <= r_k;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          if (REQ_READY) begin
            r_count <= r_count + 8'd1;
`ifdef LOCKOUT_EN
            r_fail     <= w_fail_next;
            r_lock_cnt <= '0;
`endif
          end
        end
`ifdef LOCKOUT_EN
        ST_LOCK: begin
          if (w_lock_done) r_fail <= '0;
          else             r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
